// File: rtl/mux_arbiter_pkg.sv
// Shared state encodings and owner constants for the two-requester arbiter.
// OWNER_x doubles as the mux select value routing requester x.
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/mux_arbiter_watchdog.sv
// Saturating ownership watchdog: counts owned cycles and flags the last allowed one.
// TIMEOUT of 0 disables expiry entirely.
module owner_watchdog #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit                   WD_ON = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] LIMIT = WD_ON ? TIMEOUT_W'(TIMEOUT - 1) : '0;
  localparam logic [TIMEOUT_W-1:0] MAXV  = '1;

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != MAXV)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Counter value k means the (k+1)th owned cycle is in progress.
  assign expired = WD_ON && (cnt == LIMIT);

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 mux,
// with hold-until-done grants, a one-cycle turnaround and a watchdog release.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic done,
  output logic grant_a,
  output logic grant_b,
  output logic sel,
  output logic busy,
  output logic timeout
);

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   sel_nxt, timeout_nxt;
  logic   expired;

  owner_watchdog #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_IDLE),
    .enable  (state != ST_IDLE),
    .expired (expired)
  );

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    sel_nxt     = sel;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((req_a && req_b && (last == OWNER_B)) || (req_a && !req_b)) begin
          state_nxt = ST_OWN_A;
          sel_nxt   = OWNER_A;
        end else if (req_b) begin
          state_nxt = ST_OWN_B;
          sel_nxt   = OWNER_B;
        end
      end
      ST_OWN_A: begin
        if (done || !req_a || expired) begin
          state_nxt   = ST_IDLE;
          last_nxt    = OWNER_A;
          // Only a pure watchdog release is reported.
          timeout_nxt = !done && req_a;
        end
      end
      ST_OWN_B: begin
        if (done || !req_b || expired) begin
          state_nxt   = ST_IDLE;
          last_nxt    = OWNER_B;
          timeout_nxt = !done && req_b;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      last    <= OWNER_B;
      sel     <= OWNER_A;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      sel     <= sel_nxt;
      timeout <= timeout_nxt;
    end
  end

  assign grant_a = (state == ST_OWN_A);
  assign grant_b = (state == ST_OWN_B);
  assign busy    = grant_a | grant_b;

endmodule
